// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types, defaults and elaboration helpers for SPI FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W_DFLT     = 8;
    localparam int SPI_FIFO_DEPTH_DFLT = 16;

    typedef logic [SPI_DATA_W_DFLT-1:0] spi_data_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo_mem
// Purpose  : DEPTH x DATA_W register array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fifo_mem
    import spi_pkg::*;
#(
    parameter int DATA_W = $bits(spi_data_t),
    parameter int DEPTH  = SPI_FIFO_DEPTH_DFLT,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset: contents are only meaningful once written.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/spi_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo_param
// Purpose  : Parametrised FWFT FIFO with level and almost-full/empty flags.
//            Define SPI_FIFO_ERR_EN to build sticky ovf/udf error flags.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fifo_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = $bits(spi_data_t),
    parameter int DEPTH     = SPI_FIFO_DEPTH_DFLT,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         din,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    output logic                      udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_depth  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_afull  = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] c_aempty = LVL_W'(AEMPTY_TH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
            $error("spi_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
            $error("spi_fifo_param: AFULL_TH out of range 1..DEPTH");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
            $error("spi_fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [LVL_W-1:0] r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_mem_we;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == c_depth);
    assign w_rd_acc = rd_en & ~w_empty;
    // At full, a same-cycle pop frees the slot the write lands in.
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
    assign w_mem_we = w_wr_acc & ~clr & ~rst;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    spi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wp),
        .wdata (din),
        .raddr (r_rp),
        .rdata (dout)
    );

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= c_afull);
    assign almost_empty = (r_level <= c_aempty);
    assign level        = r_level;

`ifdef SPI_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en & ~w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (rd_en & w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_fifo_param
// Purpose  : Directed plus random checks of spi_fifo_param against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fifo_param;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 4;
    localparam int LVL_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              ovf;
    logic              udf;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;

    always #5 clk = ~clk;

    spi_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .ovf          (ovf),
        .udf          (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"},  32'(level), 32'(n));
        chk({tag, ".empty"},  32'(empty), 32'(n == 0));
        chk({tag, ".full"},   32'(full),  32'(n == DEPTH));
        chk({tag, ".afull"},  32'(almost_full),  32'(n >= AFULL_TH));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
        if (n > 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
`ifdef SPI_FIFO_ERR_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
`else
        chk({tag, ".ovf"}, 32'(ovf), 32'(0));
        chk({tag, ".udf"}, 32'(udf), 32'(0));
`endif
    endtask

    // One clock: drive inputs, update the queue model from the FIFO rules, then check.
    task automatic step(input string tag, input bit w, input bit r,
                        input logic [DATA_W-1:0] d, input bit c, input bit rs);
        bit ra;
        bit wa;
        wr_en = w; rd_en = r; din = d; clr = c; rst = rs;
        @(posedge clk);
        ra = r && (q.size() > 0);
        wa = w && ((q.size() < DEPTH) || ra);
        if (rs || c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && !wa) m_ovf = 1'b1;
            if (r && q.size() == 0) m_udf = 1'b1;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Reset
        step("reset", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Fill with 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
        chk("fill.full_dout", 32'(dout), 32'h00);

        // Simultaneous read/write at full
        step("full_rw", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("full_rw.dout", 32'(dout), 32'h01);

        // Write while full is rejected
        step("full_wr", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        step("full_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("drain.aa_head", 32'(dout), 32'hAA);
        step("drain_last", 1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Underflow and empty read+write
        step("empty_rd", 1'b0, 1'b1, '0, 1'b0, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("empty_rw.dout", 32'(dout), 32'h3C);
        step("clr_a", 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Streaming with 3 in flight across pointer wrap
        for (int i = 0; i < 3; i++) step("prime", 1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);

        // clr with a write pending
        step("clr_b", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("fill7", 1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
        step("clr_wr", 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);

        // rst mid-burst
        for (int i = 0; i < 7; i++) step("burst", 1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 8'h77, 1'b0, 1'b1);

        // Random traffic, occasional flush
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                 DATA_W'($urandom), 1'($urandom_range(0, 99) < 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
